// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path: state encoding,
// ROM geometry, PC width and the default prefetch entry layout.
`timescale 1ns/1ps
package fetch_pkg;

  localparam int ROM_WORDS = 64;
  localparam int PC_W      = 64;
  localparam int IMEM_AW   = $clog2(ROM_WORDS);
  localparam int INSTR_W   = 32;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

  // A PC is fetchable only if it is word aligned and inside the ROM window.
  function automatic logic pc_legal(input logic [PC_W-1:0] pc);
    return (pc[PC_W-1:IMEM_AW+2] == '0) && (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO with registered pointers.
// Flush wins over push and pop; head is the oldest entry.
`timescale 1ns/1ps
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t push_data,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  entry_t      r_mem [DEPTH];
  logic        w_push;
  logic        w_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_pop  = pop && !empty && !flush;
  assign w_push = push && (!full || w_pop) && !flush;
  assign head   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: walks fetch_pc through an external ROM,
// buffers words in a prefetch FIFO and halts on an illegal PC until redirected.
`timescale 1ns/1ps
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [N-1:0]       imem_q,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [N-1:0]       instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               fetch_fault,
  output logic [15:0]        instr_count
);

  typedef struct packed {
    logic [N-1:0]    instr;
    logic [PC_W-1:0] pc;
  } entry_t;

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] w_fetch_pc_nxt;
  logic [15:0]     r_instr_count;
  logic            w_full;
  logic            w_empty;
  logic            w_xfer;
  logic            w_pop;
  logic            w_push;
  logic            w_pc_legal;
  entry_t          w_head;
  entry_t          w_push_data;

  assign w_xfer      = instr_valid && instr_ready;
  assign w_pop       = w_xfer && !redirect_valid;
  assign w_pc_legal  = pc_legal(r_fetch_pc);
  assign w_push_data = '{instr: imem_q, pc: r_fetch_pc};

  // fetch_pc is frozen in FAULT, so the address slice already holds there.
  assign imem_addr   = r_fetch_pc[IMEM_AW+1:2];

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_push         = 1'b0;
    if (redirect_valid) begin
      w_state_nxt    = ST_RUN;
      w_fetch_pc_nxt = redirect_pc;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!w_pc_legal) begin
            w_state_nxt = ST_FAULT;
          end else if (!w_full || w_pop) begin
            w_push         = 1'b1;
            w_fetch_pc_nxt = r_fetch_pc + 64'd4;
          end
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_fetch_pc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  // Transfers are counted even when a redirect flushes the buffer that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_count <= '0;
    end else if (w_xfer && (r_instr_count != 16'hFFFF)) begin
      r_instr_count <= r_instr_count + 16'd1;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .push_data (w_push_data),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  assign instr_valid = !w_empty;
  assign instr       = w_head.instr;
  assign instr_pc    = w_head.pc;
  assign fetch_fault = (r_state == ST_FAULT);
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: ROM model, queue-based reference model,
// directed scenarios followed by randomized ready/redirect/reset traffic.
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;

  localparam int N     = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    imem_addr;
  logic [N-1:0]  imem_q;
  logic          instr_valid;
  logic          instr_ready;
  logic [N-1:0]  instr;
  logic [63:0]   instr_pc;
  logic          redirect_valid;
  logic [63:0]   redirect_pc;
  logic          fetch_fault;
  logic [15:0]   instr_count;

  logic [N-1:0]  rom [64];

  always #5 clk = ~clk;

  assign imem_q = rom[imem_addr];

  imem_fetch_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_q         (imem_q),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault),
    .instr_count    (instr_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ment_t;

  ment_t       mq[$];
  logic [63:0] m_pc;
  bit          m_fault;
  int          m_cnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [63:0] pc);
    return (pc < 64'h100) && (pc[1:0] == 2'b00);
  endfunction

  // One clock edge of the reference behaviour, using the inputs held across that edge.
  task automatic model_step();
    bit xfer;
    if (reset) begin
      mq.delete();
      m_pc    = 64'h0;
      m_fault = 1'b0;
      m_cnt   = 0;
      return;
    end
    xfer = (mq.size() > 0) && instr_ready;
    if (xfer && m_cnt < 65535) m_cnt++;
    if (redirect_valid) begin
      mq.delete();
      m_pc    = redirect_pc;
      m_fault = 1'b0;
    end else begin
      if (xfer) void'(mq.pop_front());
      if (!m_fault) begin
        if (!legal(m_pc)) begin
          m_fault = 1'b1;
        end else if (mq.size() < DEPTH) begin
          mq.push_back('{rom[m_pc[7:2]], m_pc});
          m_pc = m_pc + 64'd4;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    check_eq("instr_valid", 64'(instr_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      check_eq("instr", 64'(instr), 64'(mq[0].instr));
      check_eq("instr_pc", instr_pc, mq[0].pc);
    end
    check_eq("fetch_fault", 64'(fetch_fault), 64'(m_fault));
    check_eq("instr_count", 64'(instr_count), 64'(m_cnt));
    check_eq("imem_addr", 64'(imem_addr), 64'(m_pc[7:2]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] held_addr;
    int         guard;
    int         got;

    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0]  = 32'hf8000001;
    rom[1]  = 32'hf8008002;
    rom[2]  = 32'hf8000203;
    rom[24] = 32'h8b1f0187;

    reset          = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    m_pc           = 64'h0;
    m_fault        = 1'b0;
    m_cnt          = 0;

    tick();
    tick();
    check_eq("reset_valid", 64'(instr_valid), 64'h0);
    check_eq("reset_count", 64'(instr_count), 64'h0);
    check_eq("reset_fault", 64'(fetch_fault), 64'h0);

    // Streaming out of reset
    reset       = 1'b0;
    instr_ready = 1'b1;
    tick();
    check_eq("stream_c1_instr", 64'(instr), 64'hf8000001);
    check_eq("stream_c1_pc", instr_pc, 64'h0);
    tick();
    check_eq("stream_c2_instr", 64'(instr), 64'hf8008002);
    check_eq("stream_c2_pc", instr_pc, 64'h4);
    tick();
    check_eq("stream_c3_instr", 64'(instr), 64'hf8000203);
    check_eq("stream_c3_pc", instr_pc, 64'h8);

    // Backpressure after reset
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("bp_addr_hold", 64'(imem_addr), 64'h2);
    check_eq("bp_head", 64'(instr), 64'hf8000001);
    instr_ready = 1'b1;
    tick();
    check_eq("bp_second", 64'(instr), 64'hf8008002);
    tick();
    check_eq("bp_third", 64'(instr), 64'hf8000203);

    // Redirect while full
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h60;
    tick();
    redirect_valid = 1'b0;
    check_eq("redir_bubble", 64'(instr_valid), 64'h0);
    tick();
    check_eq("redir_valid", 64'(instr_valid), 64'h1);
    check_eq("redir_instr", 64'(instr), 64'h8b1f0187);
    check_eq("redir_pc", instr_pc, 64'h60);

    // Illegal targets, then recovery
    instr_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      redirect_valid = 1'b1;
      redirect_pc    = (k == 0) ? 64'h100 : 64'h62;
      tick();
      redirect_valid = 1'b0;
      tick();
      held_addr = imem_addr;
      check_eq("fault_set", 64'(fetch_fault), 64'h1);
      for (int i = 0; i < 3; i++) tick();
      check_eq("fault_valid", 64'(instr_valid), 64'h0);
      check_eq("fault_addr_hold", 64'(imem_addr), 64'(held_addr));
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0;
    tick();
    redirect_valid = 1'b0;
    check_eq("recover_fault_clr", 64'(fetch_fault), 64'h0);
    tick();
    check_eq("recover_instr", 64'(instr), 64'hf8000001);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      reset          = ($urandom_range(0, 199) == 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0) || (m_fault && $urandom_range(0, 3) == 0);
      case ($urandom_range(0, 6))
        0:       redirect_pc = 64'h100;
        1:       redirect_pc = 64'h62;
        2:       redirect_pc = 64'hF0;
        3:       redirect_pc = 64'h0;
        4:       redirect_pc = {$urandom, $urandom};
        default: redirect_pc = 64'($urandom_range(0, 63)) << 2;
      endcase
      tick();
    end

    // Saturation: preload 0xFFFE transfers, redirecting back to 0 at the ROM end
    reset          = 1'b1;
    redirect_valid = 1'b0;
    tick();
    reset       = 1'b0;
    instr_ready = 1'b1;
    redirect_pc = 64'h0;
    guard       = 0;
    while (m_cnt < 16'hFFFE && guard < 80000) begin
      redirect_valid = (m_pc == 64'h100);
      tick();
      guard++;
    end
    redirect_valid = 1'b0;
    check_eq("preload_timeout", 64'(guard >= 80000), 64'h0);
    check_eq("preload_count", 64'(instr_count), 64'hFFFE);
    got   = 0;
    guard = 0;
    while (got < 3 && guard < 50) begin
      if (m_pc == 64'h100) begin
        redirect_valid = 1'b1;
      end else begin
        redirect_valid = 1'b0;
      end
      if (mq.size() > 0) got++;
      tick();
      guard++;
    end
    redirect_valid = 1'b0;
    check_eq("sat_timeout", 64'(guard >= 50), 64'h0);
    check_eq("sat_count", 64'(instr_count), 64'hFFFF);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0;
    tick();
    redirect_valid = 1'b0;
    check_eq("sat_redir_count", 64'(instr_count), 64'hFFFF);

    // Reset mid-stream with the buffer full
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    check_eq("midrst_valid", 64'(instr_valid), 64'h0);
    check_eq("midrst_count", 64'(instr_count), 64'h0);
    reset       = 1'b0;
    instr_ready = 1'b1;
    tick();
    check_eq("midrst_pc", instr_pc, 64'h0);
    check_eq("midrst_instr", 64'(instr), 64'hf8000001);
    tick();
    check_eq("midrst_pc2", instr_pc, 64'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter N, default 32: instruction width in bits, equal to the imem data width.
REQ-002 Parameter DEPTH, default 2: prefetch buffer entries; legal values are 2 or 4.
REQ-003 Clocking SHALL be one clock, clk; reset is synchronous and active-high, reset.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 imem_addr  output  6  word index to the instruction ROM; equals fetch_pc[7:2].
REQ-007 imem_q  input  N  ROM data, combinational from imem_addr in the same cycle.
REQ-008 instr_valid  output  1  buffer head holds a valid instruction.
REQ-009 instr_ready  input  1  consumer accepts the head this cycle.
REQ-010 instr  output  N  head instruction word.
REQ-011 instr_pc  output  64  byte address of the head instruction.
REQ-012 redirect_valid  input  1  branch or jump redirect request.
REQ-013 redirect_pc  input  64  byte target of the redirect.
REQ-014 fetch_fault  output  1  sticky flag: fetch halted on an illegal PC.
REQ-015 instr_count  output  16  saturating count of accepted instructions.

Function
REQ-016 A transfer SHALL occur exactly when instr_valid and instr_ready are both 1; instr and instr_pc SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-017 The block SHALL have two states: RUN and FAULT.
REQ-018 In RUN, a fetch SHALL occur when the buffer is not full, or is full and a transfer pops it in the same cycle.
- The fetch writes {imem_q, fetch_pc}.
- fetch_pc then advances by 4.
REQ-019 Fetch latency SHALL be 1 cycle: a word fetched in cycle t is visible at the head in cycle t+1 if the buffer was empty.
REQ-020 With continuous instr_ready=1 and no redirects, throughput SHALL be one instruction per cycle.
REQ-021 When fetch_pc[63:8] is nonzero, or fetch_pc[1:0] is nonzero, no fetch SHALL occur; the state goes to FAULT and fetch_fault=1.
REQ-022 Entries already buffered when a fault occurs SHALL still drain normally.
REQ-023 In FAULT, no fetch SHALL occur and imem_addr SHALL hold its last value.
REQ-024 A redirect SHALL have priority over fetch and pop in its cycle:
- the buffer is flushed;
- fetch_pc is loaded with redirect_pc;
- no fetch occurs that cycle;
- the state returns to RUN and fetch_fault clears.
REQ-025 A transfer in the same cycle as a redirect SHALL still count as accepted in instr_count.
REQ-026 After a redirect, the first instruction from the target SHALL appear at the head 2 cycles after the redirect cycle.
REQ-027 If the redirect target is illegal per REQ-021, fault entry SHALL occur in the cycle after the redirect.
REQ-028 instr_count SHALL increment on each transfer and saturate at 0xFFFF.
REQ-029 imem_addr SHALL wrap modulo 64 only through the fetch_pc[7:2] slice; fetch_pc itself SHALL never wrap silently (REQ-021 applies).

Reset
REQ-030 While reset=1 the following SHALL hold at the next edge:
- fetch_pc=0 and state=RUN;
- buffer empty and instr_valid=0;
- fetch_fault=0 and instr_count=0.
- instr and instr_pc are don't-care while instr_valid=0.
REQ-031 Reset SHALL override redirect_valid and any in-flight state.
REQ-032 The first fetch SHALL occur in the first cycle after reset deasserts.

Structure
REQ-033 A shared package fetch_pkg SHALL hold:
- the state enum fetch_state_t;
- the constant ROM_WORDS=64;
- the PC width constant 64;
- the buffer entry struct {instr, pc}.
REQ-034 The prefetch buffer SHALL be a sub-module fetch_fifo:
- a DEPTH-entry synchronous FIFO;
- ports push, pop, flush, full, empty, and head;
- flush has priority over push and pop.
REQ-035 The controller SHALL contain no memory array; imem SHALL be instantiated alongside it at the top level.

Verification
REQ-036 Release reset with instr_ready=1: cycle 1 has instr=0xf8000001 and instr_pc=0; cycle 2 has 0xf8008002 and pc 4; cycle 3 has 0xf8000203 and pc 8.
REQ-037 Hold instr_ready=0 for 5 cycles after reset, then raise it: the buffer fills to 2, imem_addr holds at 2, and 0xf8000001, 0xf8008002, 0xf8000203 then follow back-to-back with no loss or duplication.
REQ-038 Redirect with redirect_pc=0x60 while the buffer is full: instr_valid=0 in the next cycle; 2 cycles after the redirect, instr=0x8b1f0187 and instr_pc=0x60.
REQ-039 Redirect to 0x100, and separately to 0x62: fetch_fault=1, instr_valid stays 0, and imem_addr is stable; a later redirect to 0x0 clears the fault and 0xf8000001 follows.
REQ-040 Preload instr_count=0xFFFE via a 65534-transfer stream, then apply 3 more transfers: instr_count=0xFFFF and stays there; a redirect coinciding with a transfer still counts.
REQ-041 Assert reset mid-stream with the buffer full: the next cycle has instr_valid=0 and instr_count=0, and a fresh stream restarts from pc 0.
